// File: rtl/nav_sequencer.sv
// Closed-loop rover navigation sequencer: probe move, orientation, path moves, re-check.
// Optional NAV_WATCHDOG_EN adds a 2^28-cycle timeout on sense and helper wait states.
module nav_sequencer #(
  parameter int LOC_R_W = 8,
  parameter int LOC_T_W = 4,
  parameter int ORIENT_W = 5,
  parameter int SETTLE_CYCLES = 27000000,
  parameter int IR_HOLD_CYCLES = 5000000,
  parameter int MOVE_UNIT_CYCLES = 27000000,
  parameter logic [LOC_T_W+LOC_R_W-1:0] PROBE_CMD = 12'h00A,
  parameter int MAX_ITER = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         run_program,
  input  logic                         abort,
  input  logic [LOC_T_W+LOC_R_W-1:0]   target_location,
  input  logic [LOC_T_W+LOC_R_W-1:0]   rover_location,
  input  logic                         ultrasound_done,
  output logic                         run_ultrasound,
  output logic                         orient_enable,
  input  logic                         orient_done,
  output logic [LOC_T_W+LOC_R_W-1:0]   orient_loc_a,
  output logic [LOC_T_W+LOC_R_W-1:0]   orient_loc_b,
  input  logic [ORIENT_W-1:0]          orient_result,
  output logic                         path_enable,
  input  logic                         path_done,
  input  logic [LOC_T_W+LOC_R_W-1:0]   path_cmd,
  output logic                         eq_enable,
  input  logic                         eq_done,
  input  logic                         eq_equal,
  output logic [LOC_T_W+LOC_R_W-1:0]   move_command,
  output logic                         transmit_ir,
  output logic [ORIENT_W-1:0]          orientation,
  output logic [ORIENT_W-1:0]          needed_orientation,
  output logic                         busy,
  output logic                         reached_target,
  output logic                         failed,
  output logic [3:0]                   iteration,
  output logic [4:0]                   state
);
  localparam int LOC_W = LOC_T_W + LOC_R_W;
  localparam int UNIT_W = LOC_R_W + 1;
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] IR_LAST = 32'(IR_HOLD_CYCLES - 1);
  localparam logic [31:0] UNIT_LAST = 32'(MOVE_UNIT_CYCLES - 1);
  localparam logic [3:0] ITER_LIMIT = 4'(MAX_ITER);

  typedef enum logic [4:0] {
    S_IDLE, S_SENSE1, S_SETTLE1, S_PROBE_TX, S_PROBE_MOVE, S_SENSE2, S_SETTLE2,
    S_ORIENT, S_AIM, S_PATH, S_MOVE_TX, S_MOVE_WAIT, S_SENSE3, S_SETTLE3, S_CHECK
  } state_t;

  state_t state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [UNIT_W-1:0] unit_reg, unit_next;
  logic [LOC_W-1:0] target_reg, target_next, loc_a_reg, loc_a_next, loc_b_reg, loc_b_next;
  logic [LOC_W-1:0] cmd_reg, cmd_next;
  logic [ORIENT_W-1:0] orient_reg, orient_next, needed_reg, needed_next;
  logic [3:0] iter_reg, iter_next;
  logic tx_reg, tx_next, reached_reg, reached_next, failed_reg, failed_next;
  logic run_us_reg, run_us_next, orient_en_reg, orient_en_next;
  logic path_en_reg, path_en_next, eq_en_reg, eq_en_next;
  logic wdog_expired, wdog_fail;

`ifdef NAV_WATCHDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'((1 << 28) - 1);
  assign wdog_expired = (cnt_reg == WDOG_LAST);
`else
  assign wdog_expired = 1'b0;
`endif

  // A zero command still moves for one unit.
  function automatic logic [UNIT_W-1:0] move_units(input logic [LOC_W-1:0] cmd);
    return UNIT_W'(cmd[LOC_R_W-1:0]) + UNIT_W'(cmd[LOC_W-1:LOC_R_W]) + UNIT_W'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;      cnt_reg <= '0;        unit_reg <= '0;
      target_reg <= '0;         loc_a_reg <= '0;      loc_b_reg <= '0;
      cmd_reg <= '0;            tx_reg <= 1'b0;       orient_reg <= '0;
      needed_reg <= '0;         reached_reg <= 1'b0;  failed_reg <= 1'b0;
      iter_reg <= '0;           run_us_reg <= 1'b0;   orient_en_reg <= 1'b0;
      path_en_reg <= 1'b0;      eq_en_reg <= 1'b0;
    end else begin
      state_reg <= state_next;  cnt_reg <= cnt_next;  unit_reg <= unit_next;
      target_reg <= target_next; loc_a_reg <= loc_a_next; loc_b_reg <= loc_b_next;
      cmd_reg <= cmd_next;      tx_reg <= tx_next;    orient_reg <= orient_next;
      needed_reg <= needed_next; reached_reg <= reached_next; failed_reg <= failed_next;
      iter_reg <= iter_next;    run_us_reg <= run_us_next; orient_en_reg <= orient_en_next;
      path_en_reg <= path_en_next; eq_en_reg <= eq_en_next;
    end
  end

  always_comb begin
    state_next = state_reg;     cnt_next = cnt_reg + 32'd1; unit_next = unit_reg;
    target_next = target_reg;   loc_a_next = loc_a_reg;   loc_b_next = loc_b_reg;
    cmd_next = cmd_reg;         tx_next = tx_reg;         orient_next = orient_reg;
    needed_next = needed_reg;   reached_next = reached_reg; failed_next = failed_reg;
    iter_next = iter_reg;       run_us_next = 1'b0;       orient_en_next = 1'b0;
    path_en_next = 1'b0;        eq_en_next = 1'b0;        wdog_fail = 1'b0;
    if (abort) begin
      state_next = S_IDLE;
      tx_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: if (run_program) begin
          target_next = target_location;
          reached_next = 1'b0;
          failed_next = 1'b0;
          iter_next = '0;
          run_us_next = 1'b1;
          state_next = S_SENSE1;
        end
        S_SENSE1, S_SENSE2, S_SENSE3: begin
          if (ultrasound_done)
            state_next = (state_reg == S_SENSE1) ? S_SETTLE1 :
                         (state_reg == S_SENSE2) ? S_SETTLE2 : S_SETTLE3;
          else if (wdog_expired) wdog_fail = 1'b1;
        end
        S_SETTLE1: if (cnt_reg == SETTLE_LAST) begin
          loc_a_next = rover_location;
          cmd_next = PROBE_CMD;
          tx_next = 1'b1;
          state_next = S_PROBE_TX;
        end
        S_SETTLE2: if (cnt_reg == SETTLE_LAST) begin
          loc_b_next = rover_location;
          orient_en_next = 1'b1;
          state_next = S_ORIENT;
        end
        S_SETTLE3: if (cnt_reg == SETTLE_LAST) begin
          eq_en_next = 1'b1;
          state_next = S_CHECK;
        end
        S_PROBE_TX, S_MOVE_TX: if (cnt_reg == IR_LAST) begin
          tx_next = 1'b0;
          unit_next = move_units(cmd_reg);
          state_next = (state_reg == S_PROBE_TX) ? S_PROBE_MOVE : S_MOVE_WAIT;
        end
        // Inner counter spans one unit; outer count walks down the units.
        S_PROBE_MOVE, S_MOVE_WAIT: if (cnt_reg == UNIT_LAST) begin
          cnt_next = '0;
          if (unit_reg == UNIT_W'(1)) begin
            run_us_next = 1'b1;
            if (state_reg == S_MOVE_WAIT) begin
              iter_next = iter_reg + 4'd1;
              state_next = S_SENSE3;
            end else begin
              state_next = S_SENSE2;
            end
          end else begin
            unit_next = unit_reg - UNIT_W'(1);
          end
        end
        S_ORIENT: begin
          if (orient_done) begin
            orient_next = orient_result;
            loc_a_next = loc_b_reg;
            loc_b_next = target_reg;
            orient_en_next = 1'b1;
            state_next = S_AIM;
          end else if (wdog_expired) wdog_fail = 1'b1;
        end
        S_AIM: begin
          if (orient_done) begin
            needed_next = orient_result;
            path_en_next = 1'b1;
            state_next = S_PATH;
          end else if (wdog_expired) wdog_fail = 1'b1;
        end
        S_PATH: begin
          if (path_done) begin
            cmd_next = path_cmd;
            tx_next = 1'b1;
            state_next = S_MOVE_TX;
          end else if (wdog_expired) wdog_fail = 1'b1;
        end
        S_CHECK: begin
          if (eq_done) begin
            if (eq_equal) begin
              reached_next = 1'b1;
              state_next = S_IDLE;
            end else if (iter_reg == ITER_LIMIT) begin
              failed_next = 1'b1;
              state_next = S_IDLE;
            end else begin
              // Assume the previous aim was achieved and re-aim from the new position.
              orient_next = needed_reg;
              loc_a_next = rover_location;
              loc_b_next = target_reg;
              orient_en_next = 1'b1;
              state_next = S_AIM;
            end
          end else if (wdog_expired) wdog_fail = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
      if (wdog_fail) begin
        failed_next = 1'b1;
        tx_next = 1'b0;
        state_next = S_IDLE;
      end
    end
    if (state_next != state_reg) cnt_next = '0;
  end

  assign run_ultrasound = run_us_reg;
  assign orient_enable = orient_en_reg;
  assign orient_loc_a = loc_a_reg;
  assign orient_loc_b = loc_b_reg;
  assign path_enable = path_en_reg;
  assign eq_enable = eq_en_reg;
  assign move_command = cmd_reg;
  assign transmit_ir = tx_reg;
  assign orientation = orient_reg;
  assign needed_orientation = needed_reg;
  assign busy = (state_reg != S_IDLE);
  assign reached_target = reached_reg;
  assign failed = failed_reg;
  assign iteration = iter_reg;
  assign state = state_reg;
endmodule

// File: tb/tb_nav_sequencer.sv
// Bench for nav_sequencer: helper/locator models, vector table and transmit/orient scoreboards.
module tb_nav_sequencer;
  localparam int SETTLE = 4, IRH = 3, UNIT = 2, MAXI = 2;
  localparam logic [11:0] PROBE = 12'h00A;

  logic clock = 1'b0, reset = 1'b1, run_program = 1'b0, abort = 1'b0;
  logic [11:0] target_location = '0, rover_location = '0;
  logic ultrasound_done = 1'b0, run_ultrasound;
  logic orient_enable, orient_done = 1'b0;
  logic [11:0] orient_loc_a, orient_loc_b;
  logic [4:0] orient_result = '0;
  logic path_enable, path_done = 1'b0;
  logic [11:0] path_cmd = '0;
  logic eq_enable, eq_done = 1'b0, eq_equal = 1'b0;
  logic [11:0] move_command;
  logic transmit_ir, busy, reached_target, failed;
  logic [4:0] orientation, needed_orientation, state;
  logic [3:0] iteration;

  always #5 clock = ~clock;

  nav_sequencer #(.LOC_R_W(8), .LOC_T_W(4), .ORIENT_W(5), .SETTLE_CYCLES(SETTLE),
    .IR_HOLD_CYCLES(IRH), .MOVE_UNIT_CYCLES(UNIT), .PROBE_CMD(PROBE), .MAX_ITER(MAXI)) dut (
    .clock(clock), .reset(reset), .run_program(run_program), .abort(abort),
    .target_location(target_location), .rover_location(rover_location),
    .ultrasound_done(ultrasound_done), .run_ultrasound(run_ultrasound),
    .orient_enable(orient_enable), .orient_done(orient_done), .orient_loc_a(orient_loc_a),
    .orient_loc_b(orient_loc_b), .orient_result(orient_result), .path_enable(path_enable),
    .path_done(path_done), .path_cmd(path_cmd), .eq_enable(eq_enable), .eq_done(eq_done),
    .eq_equal(eq_equal), .move_command(move_command), .transmit_ir(transmit_ir),
    .orientation(orientation), .needed_orientation(needed_orientation), .busy(busy),
    .reached_target(reached_target), .failed(failed), .iteration(iteration), .state(state));

  typedef struct { logic [11:0] cmd; int hi; int gap; } tx_t;
  typedef struct { logic [11:0] a; logic [11:0] b; } or_t;
  typedef struct { logic [11:0] target; logic [11:0] path; int eq_at;
                   logic reached; logic fail; int iters; } vec_t;

  tx_t tx_q[$];
  or_t or_q[$];
  tx_t tx_e;
  or_t or_e;
  vec_t vecs[4];
  int total = 0, bad = 0;
  bit sb_en = 1'b0, us_hold = 1'b0, path_hold = 1'b0;
  logic [11:0] cur_path = '0;
  int cur_eq_at = 0, eq_seen = 0, us_count = 0, us_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] loc_fn(input int n);
    return 12'(163 + n * 293);
  endfunction

  function automatic logic [4:0] ofn(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] t;
    t = a ^ (b >> 2) ^ (a >> 7);
    return t[4:0];
  endfunction

  function automatic int gap_of(input logic [11:0] c);
    return (int'(c[7:0]) + int'(c[11:8]) + 1) * UNIT;
  endfunction

  // Ultrasound locator: reports a new location two cycles after being started.
  always begin
    @(posedge clock); #1;
    ultrasound_done = 1'b0;
    if (us_wait > 0) begin
      us_wait--;
      if (us_wait == 0) begin
        rover_location = loc_fn(us_count);
        us_count++;
        ultrasound_done = 1'b1;
      end
    end else if (run_ultrasound === 1'b1 && !us_hold) begin
      us_wait = 2;
    end
  end

  bit or_pend = 1'b0, pa_pend = 1'b0, eq_pend = 1'b0;
  logic [4:0] or_val = '0;
  always begin
    @(posedge clock); #1;
    orient_done = or_pend;
    if (or_pend) orient_result = or_val;
    or_pend = (orient_enable === 1'b1);
    or_val = ofn(orient_loc_a, orient_loc_b);
    path_done = pa_pend;
    if (pa_pend) path_cmd = cur_path;
    pa_pend = (path_enable === 1'b1) && !path_hold;
    eq_done = eq_pend;
    eq_equal = eq_pend && (eq_seen == cur_eq_at);
    eq_pend = (eq_enable === 1'b1);
    if (eq_pend) eq_seen++;
  end

  // Monitor: orient operand pairs, and each transmit burst with its hold and move gap.
  int ph = 0, hi = 0, gap = 0;
  logic [11:0] mcmd = '0;
  always @(negedge clock) begin
    if (sb_en && orient_enable === 1'b1) begin
      if (or_q.size() == 0) begin
        total++; bad++;
        $display("FAIL orient_unexpected: got a=%h b=%h want none", orient_loc_a, orient_loc_b);
      end else begin
        or_e = or_q.pop_front();
        check("orient_a", 32'(orient_loc_a), 32'(or_e.a));
        check("orient_b", 32'(orient_loc_b), 32'(or_e.b));
      end
    end
    if (busy !== 1'b1) ph = 0;
    else if (ph == 0) begin
      if (transmit_ir === 1'b1) begin ph = 1; hi = 1; mcmd = move_command; end
    end else if (ph == 1) begin
      if (transmit_ir === 1'b1) hi++;
      else begin ph = 2; gap = 1; end
    end else begin
      if (run_ultrasound === 1'b1) begin
        ph = 0;
        if (sb_en) begin
          if (tx_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got cmd=%h want none", mcmd);
          end else begin
            tx_e = tx_q.pop_front();
            check("tx_cmd", 32'(mcmd), 32'(tx_e.cmd));
            check("tx_hold", 32'(hi), 32'(tx_e.hi));
            check("move_gap", 32'(gap), 32'(tx_e.gap));
          end
        end
      end else gap++;
    end
  end

  task automatic start_prog(input logic [11:0] tgt);
    @(posedge clock); #1; target_location = tgt; run_program = 1'b1;
    @(posedge clock); #1; run_program = 1'b0; target_location = ~tgt;
  endtask

  task automatic wait_state(input logic [4:0] s, input string name);
    int cyc = 0;
    while (state !== s && cyc < 2000) begin @(posedge clock); #1; cyc++; end
    check(name, 32'(state), 32'(s));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_tx"}, 32'(transmit_ir), 0);
    check({tag, "_cmd"}, 32'(move_command), 0);
    check({tag, "_pulses"}, 32'({run_ultrasound, orient_enable, path_enable, eq_enable}), 0);
    check({tag, "_locs"}, 32'({orient_loc_a, orient_loc_b}), 0);
    check({tag, "_orient"}, 32'({orientation, needed_orientation}), 0);
    check({tag, "_status"}, 32'({reached_target, failed, iteration}), 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [11:0] l [4];
    int n, cyc;
    logic [4:0] exp_or, exp_need;
    for (int k = 0; k < 4; k++) l[k] = loc_fn(us_count + k);
    n = v.iters;
    tx_q.push_back('{PROBE, IRH, gap_of(PROBE)});
    for (int k = 0; k < n; k++) tx_q.push_back('{v.path, IRH, gap_of(v.path)});
    or_q.push_back('{l[0], l[1]});
    for (int k = 1; k <= n; k++) or_q.push_back('{l[k], v.target});
    exp_or = (n == 1) ? ofn(l[0], l[1]) : ofn(l[n-1], v.target);
    exp_need = ofn(l[n], v.target);
    cur_path = v.path; cur_eq_at = v.eq_at; eq_seen = 0; sb_en = 1'b1;
    start_prog(v.target);
    check("start_pulse", 32'(run_ultrasound), 1);
    check("busy_on", 32'(busy), 1);
    @(posedge clock); #1; run_program = 1'b1;
    @(posedge clock); #1; run_program = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 4000) begin @(posedge clock); #1; cyc++; end
    check("finish_in_time", 32'(busy), 0);
    check("reached", 32'(reached_target), 32'(v.reached));
    check("failed", 32'(failed), 32'(v.fail));
    check("iteration", 32'(iteration), 32'(v.iters));
    check("orientation", 32'(orientation), 32'(exp_or));
    check("needed", 32'(needed_orientation), 32'(exp_need));
    check("tx_low_end", 32'(transmit_ir), 0);
    check("tx_q_drained", 32'(tx_q.size()), 0);
    check("or_q_drained", 32'(or_q.size()), 0);
    $display("vec %0d target=%h path=%h iter=%0d reached=%0d failed=%0d orient=%h needed=%h",
             idx, v.target, v.path, iteration, reached_target, failed, orientation, needed_orientation);
    tx_q.delete(); or_q.delete(); sb_en = 1'b0;
    if (busy === 1'b1) begin
      abort = 1'b1; @(posedge clock); #1; abort = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{12'h3C8, 12'h305, 1, 1'b1, 1'b0, 1};
    vecs[1] = '{12'h150, 12'h000, 0, 1'b0, 1'b1, 2};
    vecs[2] = '{12'hA11, 12'hF0F, 2, 1'b1, 1'b0, 2};
    vecs[3] = '{12'h7E4, 12'hFFF, 0, 1'b0, 1'b1, 2};

    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Abort in the middle of a move transmit, then restart cleanly.
    cur_path = 12'h305; cur_eq_at = 1; eq_seen = 0;
    start_prog(12'h3C8);
    wait_state(5'd10, "reach_move_tx");
    @(posedge clock); #1; abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
    check("abort_tx", 32'(transmit_ir), 0);
    check("abort_state", 32'(state), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_status", 32'({reached_target, failed, iteration}), 0);
    $display("abort during MOVE_TX: state=%0d tx=%0d", state, transmit_ir);
    run_vec(vecs[0], 4);

    // Locator never answers: the sequencer keeps waiting in SENSE1.
    us_hold = 1'b1;
    start_prog(12'h222);
    repeat (300) @(posedge clock);
    #1;
    check("hold_state", 32'(state), 1);
    check("hold_busy", 32'(busy), 1);
    check("hold_failed", 32'(failed), 0);
    $display("withheld ultrasound_done: state=%0d busy=%0d", state, busy);
    abort = 1'b1; @(posedge clock); #1; abort = 1'b0; us_hold = 1'b0;
    check("hold_abort_idle", 32'(state), 0);

    // Reset while waiting on the path helper.
    path_hold = 1'b1; cur_path = 12'h123; cur_eq_at = 1; eq_seen = 0;
    start_prog(12'h456);
    wait_state(5'd9, "reach_path");
    reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
    check_all_zero("path_reset");
    $display("reset during PATH: state=%0d busy=%0d", state, busy);
    path_hold = 1'b0;
    run_vec(vecs[1], 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
